// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch front end: PC, 1-entry fetch slot, req/ack IMEM port and IF/ID register.
// Optional perf counters (Stall_Count/Flush_Count) exist only when FETCH_PERF_EN is defined.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
`ifdef FETCH_PERF_EN
    ,
    parameter int unsigned PERF_W    = 16
`endif
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic        PC_Write,
    input  logic [1:0]  IF_ID_Signal,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    output logic [31:0] IF_Instruction,
    output logic [31:0] ID_Instruction,
    output logic [31:0] ID_PCPlus4,
    output logic        ID_Valid
`ifdef FETCH_PERF_EN
    ,
    output logic [PERF_W-1:0] Stall_Count,
    output logic [PERF_W-1:0] Flush_Count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FULL,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] slot_q, slot_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic        slot_valid_q, slot_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pcp4_q, id_pcp4_d;
    logic        id_valid_q, id_valid_d;

    logic [31:0] target;
    logic        req;
    logic        ack;
    logic        ctrl_ok;
    logic        consume;
    logic        slot_free;

    assign target    = BranchTarget & ~32'd3;
    assign req       = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign ack       = req && IMem_Ack;
    assign ctrl_ok   = (IF_ID_Signal == 2'd0) && !PC_Write;
    assign consume   = ctrl_ok && !PCSrc && slot_valid_q;
    assign slot_free = !slot_valid_q || consume;

    assign IMem_Req       = req;
    assign IMem_Addr      = addr_q;
    assign IF_Instruction = slot_valid_q ? slot_q : NOP_INSTR;
    assign ID_Instruction = id_instr_q;
    assign ID_PCPlus4     = id_pcp4_q;
    assign ID_Valid       = id_valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        slot_d       = slot_q;
        slot_pc_d    = slot_pc_q;
        slot_valid_d = slot_valid_q;
        id_instr_d   = id_instr_q;
        id_pcp4_d    = id_pcp4_q;
        id_valid_d   = id_valid_q;

        if (PCSrc || IF_ID_Signal[1]) begin
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (IF_ID_Signal == 2'd0) begin
            if (consume) begin
                id_instr_d = slot_q;
                id_pcp4_d  = slot_pc_q + 32'd4;
                id_valid_d = 1'b1;
            end else begin
                id_instr_d = NOP_INSTR;
                id_valid_d = 1'b0;
            end
        end

        if (consume) begin
            slot_valid_d = 1'b0;
        end

        // An ack that finds the slot occupied and unconsumed is dropped; the PC
        // is not advanced, so the word is refetched once the slot drains.
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (ack) begin
                    if (PCSrc) begin
                        state_d = S_FETCH;
                    end else if (slot_free) begin
                        slot_d       = IMem_Data;
                        slot_pc_d    = addr_q;
                        slot_valid_d = 1'b1;
                        pc_d         = pc_q + 32'd4;
                        state_d      = ctrl_ok ? S_FETCH : S_FULL;
                    end else begin
                        state_d = S_FULL;
                    end
                end else if (PCSrc) begin
                    state_d = S_DRAIN;
                end
            end
            S_FULL: begin
                if (PCSrc || consume) begin
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (ack) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (PCSrc) begin
            pc_d         = target;
            slot_valid_d = 1'b0;
        end

        addr_d = (state_d == S_DRAIN) ? addr_q : pc_d;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            slot_q       <= '0;
            slot_pc_q    <= '0;
            slot_valid_q <= 1'b0;
            id_instr_q   <= NOP_INSTR;
            id_pcp4_q    <= '0;
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            slot_q       <= slot_d;
            slot_pc_q    <= slot_pc_d;
            slot_valid_q <= slot_valid_d;
            id_instr_q   <= id_instr_d;
            id_pcp4_q    <= id_pcp4_d;
            id_valid_q   <= id_valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((IF_ID_Signal == 2'd1) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if ((IF_ID_Signal[1] || PCSrc) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign Stall_Count = stall_cnt_q;
    assign Flush_Count = flush_cnt_q;
`endif

endmodule
